// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, combinational imem address, registered valid/ready output slot.
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
//
// state   | meaning
// --------+------------------------------------------------------------
// FETCH   | fetching one word per free slot cycle
// DRAIN   | PC past end of memory; waiting for the slot to empty
// HALT    | stopped; only reset exits
module fetch_unit #(
  parameter int          ADDR_W    = 5,
  parameter int          MEM_WORDS = 32,
  parameter logic [31:0] RESET_PC  = 32'h00000000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic              halted,
`ifdef FETCH_PERF_EN
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_flushed,
`endif
  output logic              misalign_err
);

  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [31:0] NOP       = 32'h00000013;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_next4;
  logic        slot_free;
  logic        redir_mis;
  logic        redir_oor;
  logic        pc_in;
  logic        active;
  logic        load;

  assign im_addr   = pc[ADDR_W+1:2];
  assign pc_next4  = pc + 32'd4;
  assign slot_free = !out_valid || out_ready;
  assign redir_mis = redirect_target[1:0] != 2'b00;
  assign redir_oor = redirect_target >= MEM_BYTES;
  assign pc_in     = pc < MEM_BYTES;
  assign active    = (state == S_FETCH) || (state == S_DRAIN);
  assign load      = (state == S_FETCH) && !redirect_valid && slot_free && pc_in;
  assign halted    = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      out_valid    <= 1'b0;
      out_inst     <= NOP;
      out_pc       <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        S_FETCH, S_DRAIN: begin
          if (redirect_valid) begin
            // a redirect always flushes the slot; a concurrent handshake still counts as a transfer
            out_valid <= 1'b0;
            if (redir_mis) begin
              misalign_err <= 1'b1;
              state        <= S_HALT;
            end else begin
              pc    <= redirect_target;
              state <= redir_oor ? S_DRAIN : S_FETCH;
            end
          end else if (state == S_FETCH) begin
            if (load) begin
              out_inst  <= im_inst;
              out_pc    <= pc;
              out_valid <= 1'b1;
              pc        <= pc_next4;
              if (pc_next4 >= MEM_BYTES) state <= S_DRAIN;
            end else if (out_ready) begin
              out_valid <= 1'b0;
            end
          end else if (slot_free) begin
            // slot empties this edge (or already empty): nothing left to hand over
            out_valid <= 1'b0;
            state     <= S_HALT;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_HALT;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic flush;
  assign flush = active && redirect_valid && out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= 16'h0;
      perf_flushed <= 16'h0;
    end else begin
      if (load)  perf_fetched <= perf_fetched + 16'd1;
      if (flush) perf_flushed <= perf_flushed + 16'd1;
    end
  end
`else
  logic unused_active;
  assign unused_active = active;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus hand sequences for halt/drain/reset corners.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  im_addr;
  logic [31:0] im_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halted;
  logic        misalign_err;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_flushed;
`endif

  logic [31:0] mem [32];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  assign im_inst = mem[im_addr];

  fetch_unit #(.ADDR_W(5), .MEM_WORDS(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .im_addr(im_addr), .im_inst(im_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halted(halted),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched), .perf_flushed(perf_flushed),
`endif
    .misalign_err(misalign_err)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rt;
    logic        e_valid;
    logic        chk_slot;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [4:0]  e_addr;
    logic        e_halt;
    logic        e_err;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic rdy, input logic rv, input logic [31:0] rt);
    reset           = rst;
    out_ready       = rdy;
    redirect_valid  = rv;
    redirect_target = rt;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic rdy, input logic rv, input logic [31:0] rt,
                              input logic ev, input logic cs, input logic [31:0] ep, input logic [31:0] ei,
                              input logic [4:0] ea, input logic eh, input logic ee);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rt = rt;
    v.e_valid = ev; v.chk_slot = cs; v.e_pc = ep; v.e_inst = ei;
    v.e_addr = ea; v.e_halt = eh; v.e_err = ee;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA5000000 | (i << 8) | 32'h13;
    mem[0] = 32'h00300413;
    mem[1] = 32'h00100493;

    //             rst rdy rv target     valid chk pc       inst            addr  halt err
    vecs[0]  = mk(1, 1, 0, 32'h0,  0, 1, 32'h00, 32'h00000013, 5'd0,  0, 0);
    vecs[1]  = mk(0, 1, 0, 32'h0,  1, 1, 32'h00, 32'h00300413, 5'd1,  0, 0);
    vecs[2]  = mk(0, 1, 0, 32'h0,  1, 1, 32'h04, 32'h00100493, 5'd2,  0, 0);
    vecs[3]  = mk(0, 1, 0, 32'h0,  1, 1, 32'h08, 32'hA5000213, 5'd3,  0, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0,  1, 1, 32'h08, 32'hA5000213, 5'd3,  0, 0);
    vecs[5]  = mk(0, 0, 0, 32'h0,  1, 1, 32'h08, 32'hA5000213, 5'd3,  0, 0);
    vecs[6]  = mk(0, 0, 0, 32'h0,  1, 1, 32'h08, 32'hA5000213, 5'd3,  0, 0);
    vecs[7]  = mk(0, 1, 0, 32'h0,  1, 1, 32'h0C, 32'hA5000313, 5'd4,  0, 0);
    vecs[8]  = mk(0, 1, 0, 32'h0,  1, 1, 32'h10, 32'hA5000413, 5'd5,  0, 0);
    vecs[9]  = mk(0, 1, 1, 32'h40, 0, 0, 32'h00, 32'h0,        5'd16, 0, 0);
    vecs[10] = mk(0, 0, 0, 32'h0,  1, 1, 32'h40, 32'hA5001013, 5'd17, 0, 0);
    vecs[11] = mk(0, 0, 1, 32'h34, 0, 0, 32'h00, 32'h0,        5'd13, 0, 0);
    vecs[12] = mk(0, 0, 0, 32'h0,  1, 1, 32'h34, 32'hA5000D13, 5'd14, 0, 0);
    vecs[13] = mk(0, 0, 0, 32'h0,  1, 1, 32'h34, 32'hA5000D13, 5'd14, 0, 0);
    vecs[14] = mk(0, 1, 1, 32'h08, 0, 0, 32'h00, 32'h0,        5'd2,  0, 0);
    vecs[15] = mk(0, 1, 0, 32'h0,  1, 1, 32'h08, 32'hA5000213, 5'd3,  0, 0);

    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rt);
      check($sformatf("v%0d valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d addr", i), 32'(im_addr), 32'(vecs[i].e_addr));
      check($sformatf("v%0d halted", i), 32'(halted), 32'(vecs[i].e_halt));
      check($sformatf("v%0d err", i), 32'(misalign_err), 32'(vecs[i].e_err));
      if (vecs[i].chk_slot) begin
        check($sformatf("v%0d pc", i), out_pc, vecs[i].e_pc);
        check($sformatf("v%0d inst", i), out_inst, vecs[i].e_inst);
      end
    end
`ifdef FETCH_PERF_EN
    check("perf_fetched table", 32'(perf_fetched), 32'd8);
    check("perf_flushed table", 32'(perf_flushed), 32'd1);
`endif

    // misaligned redirect with a valid, stalled slot -> HALT with sticky error
    step(0, 0, 1, 32'h36);
    check("mis valid", 32'(out_valid), 32'd0);
    check("mis halted", 32'(halted), 32'd1);
    check("mis err", 32'(misalign_err), 32'd1);
    check("mis pc held", 32'(im_addr), 32'd3);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, k[0], 32'h10);
      check("halt valid", 32'(out_valid), 32'd0);
      check("halt halted", 32'(halted), 32'd1);
      check("halt err", 32'(misalign_err), 32'd1);
      check("halt pc", 32'(im_addr), 32'd3);
    end
`ifdef FETCH_PERF_EN
    check("perf_fetched halt", 32'(perf_fetched), 32'd8);
    check("perf_flushed mis", 32'(perf_flushed), 32'd2);
`endif

    // free run through the whole memory
    step(1, 1, 0, 32'h0);
    check("rst err clr", 32'(misalign_err), 32'd0);
    check("rst halted clr", 32'(halted), 32'd0);
    for (int k = 0; k < 32; k++) begin
      step(0, 1, 0, 32'h0);
      check($sformatf("run%0d valid", k), 32'(out_valid), 32'd1);
      check($sformatf("run%0d pc", k), out_pc, 32'(k * 4));
      check($sformatf("run%0d inst", k), out_inst, mem[k]);
      check($sformatf("run%0d halted", k), 32'(halted), 32'd0);
    end
    step(0, 1, 0, 32'h0);
    check("run end halted", 32'(halted), 32'd1);
    check("run end valid", 32'(out_valid), 32'd0);
`ifdef FETCH_PERF_EN
    check("perf_fetched run", 32'(perf_fetched), 32'd32);
    check("perf_flushed run", 32'(perf_flushed), 32'd0);
`endif

    // out-of-range redirect: DRAIN then HALT without loading
    step(1, 1, 0, 32'h0);
    step(0, 1, 0, 32'h0);
    check("oor pre valid", 32'(out_valid), 32'd1);
    step(0, 0, 1, 32'h80);
    check("drain valid", 32'(out_valid), 32'd0);
    check("drain halted", 32'(halted), 32'd0);
    step(0, 1, 0, 32'h0);
    check("drain->halt halted", 32'(halted), 32'd1);
    check("drain->halt valid", 32'(out_valid), 32'd0);

    // aligned in-range redirect from DRAIN returns to FETCH
    step(1, 1, 0, 32'h0);
    step(0, 1, 1, 32'h80);
    step(0, 1, 1, 32'h04);
    check("drain ret valid", 32'(out_valid), 32'd0);
    check("drain ret halted", 32'(halted), 32'd0);
    step(0, 1, 0, 32'h0);
    check("drain ret pc", out_pc, 32'h04);
    check("drain ret load", 32'(out_valid), 32'd1);

    // reset asserted while in DRAIN
    step(0, 1, 1, 32'h80);
    step(1, 1, 1, 32'h36);
    check("rst drain valid", 32'(out_valid), 32'd0);
    check("rst drain addr", 32'(im_addr), 32'd0);
    check("rst drain err", 32'(misalign_err), 32'd0);
    check("rst drain halted", 32'(halted), 32'd0);
    step(0, 1, 0, 32'h0);
    check("resume valid", 32'(out_valid), 32'd1);
    check("resume pc", out_pc, 32'h0);
    check("resume inst", out_inst, 32'h00300413);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
